result_writeback_stage: RTL and testbench

Lane-level writeback stage: the return path from the functional units to the vector register file. It accepts result words from NrSources VFU result ports (ALU, MFPU, mask unit, slide/load) into per-source FIFOs. It then arbitrates each FIFO head onto the VRF bank write port selected by its address. The operand queues feed VFUs from the VRF; this block drains VFU results back into it.

---
 rtl/result_writeback_stage.sv | 146 ++++++++++++++
 tb/tb_result_writeback_stage.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_stage.sv
// Writeback stage: per-source result FIFOs drained onto VRF bank write ports by per-bank round-robin arbiters.
// Latency: a word accepted at edge t can be written in cycle t+1. Backpressure: result_gnt_o is !full, and a busy bank stalls its heads.
module result_writeback_stage #(
    parameter int unsigned NrSources  = 4,
    parameter int unsigned NrBanks    = 8,
    parameter int unsigned AddrWidth  = 10,
    parameter int unsigned QueueDepth = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrSources-1:0]                 result_req_i,
    input  logic [NrSources-1:0][AddrWidth-1:0]  result_addr_i,
    input  logic [NrSources-1:0][63:0]           result_wdata_i,
    input  logic [NrSources-1:0][7:0]            result_be_i,
    output logic [NrSources-1:0]                 result_gnt_o,
    output logic [NrSources-1:0]                 result_final_gnt_o,
    input  logic [NrBanks-1:0]                   vrf_bank_busy_i,
    output logic [NrBanks-1:0]                   vrf_req_o,
    output logic [NrBanks-1:0][AddrWidth-1:0]    vrf_addr_o,
    output logic [NrBanks-1:0][63:0]             vrf_wdata_o,
    output logic [NrBanks-1:0][7:0]              vrf_be_o,
    output logic                                 wb_idle_o
);

    localparam int unsigned BankW = (NrBanks > 1) ? $clog2(NrBanks) : 1;
    localparam int unsigned SrcW  = (NrSources > 1) ? $clog2(NrSources) : 1;
    localparam int unsigned PtrW  = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int unsigned CntW  = $clog2(QueueDepth + 1);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [63:0]          wdata;
        logic [7:0]           be;
    } wb_entry_t;

    wb_entry_t            fifo_mem  [NrSources][QueueDepth];
    logic [PtrW-1:0]      rd_ptr    [NrSources];
    logic [PtrW-1:0]      wr_ptr    [NrSources];
    logic [CntW-1:0]      occ       [NrSources];
    wb_entry_t            head      [NrSources];
    logic [BankW-1:0]     head_bank [NrSources];
    logic [NrSources-1:0] fifo_empty;
    logic [NrSources-1:0] fifo_full;
    logic [NrSources-1:0] push;
    logic [NrSources-1:0] pop;

    logic [SrcW-1:0]      rr_ptr    [NrBanks];
    logic [SrcW-1:0]      bank_src  [NrBanks];
    logic [NrBanks-1:0]   bank_gnt;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(QueueDepth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int s = 0; s < NrSources; s++) begin
            fifo_empty[s] = (occ[s] == '0);
            fifo_full[s]  = (occ[s] == CntW'(QueueDepth));
            head[s]       = fifo_mem[s][rd_ptr[s]];
            head_bank[s]  = head[s].addr[BankW-1:0];
        end
    end

    // Accept is purely occupancy based: a same-cycle pop never frees a slot early.
    assign result_gnt_o       = ~fifo_full;
    assign push               = result_req_i & ~fifo_full;
    assign wb_idle_o          = &fifo_empty;
    assign result_final_gnt_o = pop;

    always_comb begin
        logic [SrcW-1:0] cand;
        cand        = '0;
        bank_gnt    = '0;
        pop         = '0;
        vrf_req_o   = '0;
        vrf_addr_o  = '0;
        vrf_wdata_o = '0;
        vrf_be_o    = '0;
        for (int b = 0; b < NrBanks; b++) begin
            bank_src[b] = '0;
        end
        for (int b = 0; b < NrBanks; b++) begin
            for (int k = 0; k < NrSources; k++) begin
                cand = SrcW'((int'(rr_ptr[b]) + k) % int'(NrSources));
                if (!bank_gnt[b] && !vrf_bank_busy_i[b] && !fifo_empty[cand] &&
                    (head_bank[cand] == BankW'(b))) begin
                    bank_gnt[b] = 1'b1;
                    bank_src[b] = cand;
                end
            end
            if (bank_gnt[b]) begin
                pop[bank_src[b]] = 1'b1;
                vrf_req_o[b]     = 1'b1;
                vrf_addr_o[b]    = head[bank_src[b]].addr;
                vrf_wdata_o[b]   = head[bank_src[b]].wdata;
                vrf_be_o[b]      = head[bank_src[b]].be;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NrSources; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                occ[s]    <= '0;
            end
            for (int b = 0; b < NrBanks; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int s = 0; s < NrSources; s++) begin
                if (push[s]) begin
                    wr_ptr[s] <= next_ptr(wr_ptr[s]);
                end
                if (pop[s]) begin
                    rd_ptr[s] <= next_ptr(rd_ptr[s]);
                end
                case ({push[s], pop[s]})
                    2'b10:   occ[s] <= occ[s] + 1'b1;
                    2'b01:   occ[s] <= occ[s] - 1'b1;
                    default: occ[s] <= occ[s];
                endcase
            end
            // Winner moves to lowest priority; an idle or fully stalled bank keeps its pointer.
            for (int b = 0; b < NrBanks; b++) begin
                if (bank_gnt[b]) begin
                    rr_ptr[b] <= (bank_src[b] == SrcW'(NrSources - 1)) ? '0 : bank_src[b] + 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < NrSources; s++) begin
            if (push[s]) begin
                fifo_mem[s][wr_ptr[s]] <= {result_addr_i[s], result_wdata_i[s], result_be_i[s]};
            end
        end
    end

endmodule

// File: tb/tb_result_writeback_stage.sv
// Bench for result_writeback_stage: per-source scoreboard of accepted words plus scenario tasks.
module tb_result_writeback_stage;

    localparam int NS = 4;
    localparam int NB = 8;
    localparam int AW = 10;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NS-1:0]            result_req_i = '0;
    logic [NS-1:0][AW-1:0]    result_addr_i = '0;
    logic [NS-1:0][63:0]      result_wdata_i = '0;
    logic [NS-1:0][7:0]       result_be_i = '0;
    logic [NS-1:0]            result_gnt_o;
    logic [NS-1:0]            result_final_gnt_o;
    logic [NB-1:0]            vrf_bank_busy_i = '0;
    logic [NB-1:0]            vrf_req_o;
    logic [NB-1:0][AW-1:0]    vrf_addr_o;
    logic [NB-1:0][63:0]      vrf_wdata_o;
    logic [NB-1:0][7:0]       vrf_be_o;
    logic                     wb_idle_o;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        logic [7:0]    be;
    } exp_t;

    exp_t sb [NS][$];
    int   n_cmp = 0;
    int   n_err = 0;

    result_writeback_stage #(
        .NrSources(NS), .NrBanks(NB), .AddrWidth(AW), .QueueDepth(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .result_req_i(result_req_i),
        .result_addr_i(result_addr_i),
        .result_wdata_i(result_wdata_i),
        .result_be_i(result_be_i),
        .result_gnt_o(result_gnt_o),
        .result_final_gnt_o(result_final_gnt_o),
        .vrf_bank_busy_i(vrf_bank_busy_i),
        .vrf_req_o(vrf_req_o),
        .vrf_addr_o(vrf_addr_o),
        .vrf_wdata_o(vrf_wdata_o),
        .vrf_be_o(vrf_be_o),
        .wb_idle_o(wb_idle_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: inputs are stable at the falling edge, so writes are checked and accepted words recorded there.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        int   b;
        logic nz;
        if (rst_i) begin
            for (int s = 0; s < NS; s++) sb[s].delete();
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (result_final_gnt_o[s]) begin
                    n_cmp++;
                    if (sb[s].size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected src%0d: write of addr %h, none queued", s, vrf_addr_o[s]);
                    end else begin
                        e = sb[s].pop_front();
                        b = int'(e.addr[2:0]);
                        if (vrf_req_o[b] !== 1'b1 || vrf_addr_o[b] !== e.addr ||
                            vrf_wdata_o[b] !== e.wdata || vrf_be_o[b] !== e.be) begin
                            n_err++;
                            $display("FAIL sb_write src%0d bank%0d: got req=%b a=%h d=%h be=%h, want a=%h d=%h be=%h",
                                     s, b, vrf_req_o[b], vrf_addr_o[b], vrf_wdata_o[b], vrf_be_o[b],
                                     e.addr, e.wdata, e.be);
                        end
                    end
                end
            end
            n_cmp++;
            if ($countones(vrf_req_o) != $countones(result_final_gnt_o)) begin
                n_err++;
                $display("FAIL req_vs_final: vrf_req=%b final_gnt=%b", vrf_req_o, result_final_gnt_o);
            end
            nz = 1'b0;
            for (int k = 0; k < NB; k++) begin
                if (!vrf_req_o[k] && (vrf_addr_o[k] != '0 || vrf_wdata_o[k] != '0 || vrf_be_o[k] != '0))
                    nz = 1'b1;
            end
            n_cmp++;
            if (nz !== 1'b0) begin
                n_err++;
                $display("FAIL idle_bank_zero: vrf_req=%b but ungranted bank data non-zero", vrf_req_o);
            end
            for (int s = 0; s < NS; s++) begin
                if (result_req_i[s] && result_gnt_o[s])
                    sb[s].push_back({result_addr_i[s], result_wdata_i[s], result_be_i[s]});
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (vrf_req_o !== '0 || result_gnt_o !== 4'b1111 || result_final_gnt_o !== '0 ||
            wb_idle_o !== 1'b1 || vrf_wdata_o !== '0) begin
            n_err++;
            $display("FAIL reset_state: req=%b gnt=%b final=%b idle=%b, want 0/1111/0000/1",
                     vrf_req_o, result_gnt_o, result_final_gnt_o, wb_idle_o);
        end
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_single_write();
        step();
        result_req_i[1]   = 1'b1;
        result_addr_i[1]  = 10'h013;
        result_wdata_i[1] = 64'hDEADBEEF_CAFEF00D;
        result_be_i[1]    = 8'hFF;
        @(negedge clk_i);
        n_cmp++;
        if (result_gnt_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL single_gnt: got %b want 1", result_gnt_o[1]);
        end
        step();
        result_req_i = '0;
        @(negedge clk_i);
        n_cmp++;
        if (vrf_req_o !== 8'h08 || vrf_addr_o[3] !== 10'h013 || vrf_wdata_o[3] !== 64'hDEADBEEF_CAFEF00D ||
            vrf_be_o[3] !== 8'hFF || result_final_gnt_o !== 4'b0010 || wb_idle_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_write: req=%b a=%h d=%h be=%h final=%b idle=%b",
                     vrf_req_o, vrf_addr_o[3], vrf_wdata_o[3], vrf_be_o[3], result_final_gnt_o, wb_idle_o);
        end
        step();
        @(negedge clk_i);
        n_cmp++;
        if (wb_idle_o !== 1'b1 || vrf_req_o !== '0) begin
            n_err++;
            $display("FAIL single_idle: idle=%b req=%b, want 1/0", wb_idle_o, vrf_req_o);
        end
    endtask

    task automatic test_rr_conflict();
        logic [3:0] want;
        step();
        vrf_bank_busy_i = 8'h20;
        for (int w = 0; w < 2; w++) begin
            result_req_i = 4'hF;
            for (int s = 0; s < NS; s++) begin
                result_addr_i[s]  = AW'(10'h105 + s * 8 + w * 64);
                result_wdata_i[s] = 64'hAB00_0000_0000_0000 | 64'(s * 256 + w);
                result_be_i[s]    = 8'(8'h01 << s);
            end
            step();
        end
        result_req_i = '0;
        @(negedge clk_i);
        n_cmp++;
        if (result_gnt_o !== 4'b0000 || vrf_req_o !== '0) begin
            n_err++;
            $display("FAIL rr_full_busy: gnt=%b req=%b, want 0000/0", result_gnt_o, vrf_req_o);
        end
        step();
        vrf_bank_busy_i = '0;
        for (int k = 0; k < 8; k++) begin
            want = 4'b0001 << (k % 4);
            @(negedge clk_i);
            n_cmp++;
            if (result_final_gnt_o !== want || vrf_req_o !== 8'h20) begin
                n_err++;
                $display("FAIL rr_grant k=%0d: final=%b req=%b, want %b/00100000",
                         k, result_final_gnt_o, vrf_req_o, want);
            end
            step();
        end
        @(negedge clk_i);
        n_cmp++;
        if (wb_idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL rr_drain: idle=%b want 1", wb_idle_o);
        end
    endtask

    task automatic test_parallel_banks();
        step();
        result_req_i = 4'hF;
        for (int s = 0; s < NS; s++) begin
            result_addr_i[s]  = AW'(10'h080 + 2 * s);
            result_wdata_i[s] = 64'h1234_0000_0000_0000 | 64'(s);
            result_be_i[s]    = 8'hF0;
        end
        step();
        result_req_i = '0;
        @(negedge clk_i);
        n_cmp++;
        if (vrf_req_o !== 8'h55 || result_final_gnt_o !== 4'b1111) begin
            n_err++;
            $display("FAIL parallel: req=%b final=%b, want 01010101/1111", vrf_req_o, result_final_gnt_o);
        end
        step();
        @(negedge clk_i);
        n_cmp++;
        if (wb_idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL parallel_drain: idle=%b want 1", wb_idle_o);
        end
    endtask

    task automatic test_back_pressure();
        logic want;
        step();
        vrf_bank_busy_i = 8'h04;
        result_req_i[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            result_addr_i[2]  = AW'(10'h0C2 + i * 8);
            result_wdata_i[2] = 64'h0BAD_0000_0000_0000 | 64'(i);
            result_be_i[2]    = 8'h3C;
            want = (i < 2);
            @(negedge clk_i);
            n_cmp++;
            if (result_gnt_o[2] !== want || vrf_req_o !== '0 || result_final_gnt_o !== '0) begin
                n_err++;
                $display("FAIL bp_stall i=%0d: gnt2=%b req=%b final=%b, want %b/0/0",
                         i, result_gnt_o[2], vrf_req_o, result_final_gnt_o, want);
            end
            step();
        end
        vrf_bank_busy_i = '0;
        @(negedge clk_i);
        n_cmp++;
        if (vrf_req_o !== 8'h04 || result_final_gnt_o !== 4'b0100 || result_gnt_o[2] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_resume: req=%b final=%b gnt2=%b, want 00000100/0100/0",
                     vrf_req_o, result_final_gnt_o, result_gnt_o[2]);
        end
        step();
        @(negedge clk_i);
        n_cmp++;
        if (result_gnt_o[2] !== 1'b1 || result_final_gnt_o !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_after: gnt2=%b final=%b, want 1/0100", result_gnt_o[2], result_final_gnt_o);
        end
        step();
        result_req_i = '0;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk_i);
        n_cmp++;
        if (wb_idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drain: idle=%b want 1", wb_idle_o);
        end
    endtask

    task automatic test_full_with_pop();
        int w;
        step();
        vrf_bank_busy_i = 8'h80;
        result_req_i[3] = 1'b1;
        for (w = 0; w < 2; w++) begin
            result_addr_i[3]  = AW'(10'h207 + w * 8);
            result_wdata_i[3] = 64'hF00D_0000_0000_0000 | 64'(w);
            result_be_i[3]    = 8'(w + 1);
            step();
        end
        result_addr_i[3]  = AW'(10'h207 + w * 8);
        result_wdata_i[3] = 64'hF00D_0000_0000_0000 | 64'(w);
        result_be_i[3]    = 8'(w + 1);
        @(negedge clk_i);
        n_cmp++;
        if (result_gnt_o[3] !== 1'b0) begin
            n_err++;
            $display("FAIL fwp_full: gnt3=%b want 0", result_gnt_o[3]);
        end
        step();
        vrf_bank_busy_i = '0;
        @(negedge clk_i);
        n_cmp++;
        if (result_gnt_o[3] !== 1'b0 || result_final_gnt_o !== 4'b1000) begin
            n_err++;
            $display("FAIL fwp_cycle_c: gnt3=%b final=%b, want 0/1000", result_gnt_o[3], result_final_gnt_o);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (result_gnt_o[3] !== 1'b1 || result_final_gnt_o !== 4'b1000) begin
                n_err++;
                $display("FAIL fwp_stream i=%0d: gnt3=%b final=%b, want 1/1000",
                         i, result_gnt_o[3], result_final_gnt_o);
            end
            step();
            w++;
            result_addr_i[3]  = AW'(10'h207 + w * 8);
            result_wdata_i[3] = 64'hF00D_0000_0000_0000 | 64'(w);
            result_be_i[3]    = 8'(w + 1);
        end
        result_req_i = '0;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk_i);
        n_cmp++;
        if (wb_idle_o !== 1'b1) begin
            n_err++;
            $display("FAIL fwp_drain: idle=%b want 1", wb_idle_o);
        end
    endtask

    task automatic test_reset_mid_traffic();
        step();
        vrf_bank_busy_i = 8'hFF;
        result_req_i    = 4'hF;
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < NS; s++) begin
                result_addr_i[s]  = AW'(10'h300 + s * 3 + w * 64);
                result_wdata_i[s] = 64'hDEAD_0000_0000_0000 | 64'(s * 16 + w);
            end
            step();
        end
        result_req_i = '0;
        #2;
        rst_i = 1'b1;
        #1;
        vrf_bank_busy_i = '0;
        #1;
        n_cmp++;
        if (vrf_req_o !== '0 || result_gnt_o !== 4'b1111 || wb_idle_o !== 1'b1 || result_final_gnt_o !== '0) begin
            n_err++;
            $display("FAIL async_reset: req=%b gnt=%b idle=%b final=%b, want 0/1111/1/0000",
                     vrf_req_o, result_gnt_o, wb_idle_o, result_final_gnt_o);
        end
        step();
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (vrf_req_o !== '0 || wb_idle_o !== 1'b1) begin
                n_err++;
                $display("FAIL post_reset i=%0d: req=%b idle=%b, want 0/1", i, vrf_req_o, wb_idle_o);
            end
            step();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int left;
        test_reset();
        test_single_write();
        test_rr_conflict();
        test_parallel_banks();
        test_back_pressure();
        test_full_with_pop();
        test_reset_mid_traffic();
        left = 0;
        for (int s = 0; s < NS; s++) left += sb[s].size();
        n_cmp++;
        if (left != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d words never written, want 0", left);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
